// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: absorbs producer bursts and issues one
// single-cycle tx_strobe per byte, paced by tx_ready and a fixed post-strobe holdoff.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned HOLDOFF    = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [7:0]            in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [7:0]            tx_data_o,
   output logic                  tx_strobe_o,
   input  logic                  tx_ready_i,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  empty_o,
   output logic                  overflow_o,
   input  logic                  overflow_clear_i
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned CntW  = $clog2(HOLDOFF + 1);

   localparam logic [DEPTH_LOG2:0] FullLevel = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [CntW-1:0]     HoldLoad  = CntW'(HOLDOFF);
   localparam logic [CntW-1:0]     CntOne    = CntW'(1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StStrobe = 2'd1;
   localparam logic [1:0] StHold   = 2'd2;
   localparam logic [1:0] StWait   = 2'd3;

   logic [7:0]            mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [1:0]            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  overflow_q, overflow_d;

   logic full;
   logic wr_en;
   logic pop;

   // Both decisions use registered level only, so a same-cycle pop never admits a write
   // and a same-cycle write never triggers a pop.
   assign full  = (level_q == FullLevel);
   assign wr_en = in_valid_i && !full;
   assign pop   = (state_q == StIdle) && (level_q != '0) && tx_ready_i;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      level_d    = level_q;
      tx_data_d  = tx_data_q;
      overflow_d = overflow_q;

      if (wr_en) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d    = rptr_q + 1'b1;
         tx_data_d = mem_q[rptr_q];
      end

      unique case ({wr_en, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (in_valid_i && full) begin
         overflow_d = 1'b1;
      end else if (overflow_clear_i) begin
         overflow_d = 1'b0;
      end
   end

   // tx_ready is deliberately ignored in StStrobe and StHold: the transmitter's ready
   // may still read high for a cycle or two after it has accepted a byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StStrobe;
            end
         end
         StStrobe: begin
            cnt_d   = HoldLoad;
            state_d = StHold;
         end
         StHold: begin
            cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            if (cnt_q <= CntOne) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (tx_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wptr_q] <= in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready_o  = !full;
   assign empty_o     = (level_q == '0);
   assign level_o     = level_q;
   assign tx_data_o   = tx_data_q;
   assign tx_strobe_o = (state_q == StStrobe);
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a directed vector table, corner-case sequences and a random run,
// all compared against constants or a queue-based timing model of the strobe engine.
module tb_uart_tx_fifo;

   localparam int unsigned DepthLog2 = 4;
   localparam int unsigned Holdoff   = 2;
   localparam int unsigned Depth     = 1 << DepthLog2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [7:0]           in_data = 8'h00;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [7:0]           tx_data;
   logic                 tx_strobe;
   logic                 tx_ready = 1'b0;
   logic [DepthLog2:0]   level;
   logic                 empty;
   logic                 overflow;
   logic                 overflow_clear = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DEPTH_LOG2 (DepthLog2),
      .HOLDOFF    (Holdoff)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .in_data_i        (in_data),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .tx_data_o        (tx_data),
      .tx_strobe_o      (tx_strobe),
      .tx_ready_i       (tx_ready),
      .level_o          (level),
      .empty_o          (empty),
      .overflow_o       (overflow),
      .overflow_clear_i (overflow_clear)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int         obs_cyc[$];
   logic [7:0] obs_data[$];

   // Reference model: byte queue plus "engine free from cycle N" arithmetic.
   logic [7:0] m_q[$];
   bit         m_idle = 1'b1;
   int         m_wait_start = 0;
   bit         m_strobe = 1'b0;
   logic [7:0] m_data = 8'h00;
   bit         m_ovf = 1'b0;
   bit         m_wr = 1'b0;

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         rdy;
      bit         clr;
      bit         rst;
      int         lvl;
      bit         stb;
      logic [7:0] dat;
      bit         ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic row(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                      input bit rst, input int lvl, input bit stb, input logic [7:0] dat,
                      input bit ovf);
      vec_t r;
      r.v = v; r.d = d; r.rdy = rdy; r.clr = clr; r.rst = rst;
      r.lvl = lvl; r.stb = stb; r.dat = dat; r.ovf = ovf;
      tbl.push_back(r);
   endtask

   // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
   task automatic tick(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                       input bit rst);
      in_valid = v;
      in_data = d;
      tx_ready = rdy;
      overflow_clear = clr;
      reset = rst;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (tx_strobe) begin
         obs_cyc.push_back(cyc);
         obs_data.push_back(tx_data);
      end
   endtask

   // A pop at cycle c shows its strobe at c+1, ignores ready through c+1+Holdoff and
   // can first leave the wait at c+2+Holdoff.
   task automatic model_step(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                             input bit rst);
      bit full;
      bit pop;
      bit leave;
      if (rst) begin
         m_q.delete();
         m_idle = 1'b1;
         m_strobe = 1'b0;
         m_data = 8'h00;
         m_ovf = 1'b0;
         m_wr = 1'b0;
         return;
      end
      full = (m_q.size() == Depth);
      pop = m_idle && (m_q.size() != 0) && rdy;
      leave = !m_idle && (cyc >= m_wait_start) && rdy;
      m_wr = v && !full;
      if (v && full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_strobe = pop;
      if (pop) begin
         m_data = m_q.pop_front();
         m_idle = 1'b0;
         m_wait_start = cyc + 2 + Holdoff;
      end
      if (leave) m_idle = 1'b1;
      if (m_wr) m_q.push_back(d);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                        input bit rst);
      model_step(v, d, rdy, clr, rst);
      tick(v, d, rdy, clr, rst);
      chk("model level", int'(level), m_q.size());
      chk("model empty", int'(empty), int'(m_q.size() == 0));
      chk("model in_ready", int'(in_ready), int'(m_q.size() != Depth));
      chk("model tx_strobe", int'(tx_strobe), int'(m_strobe));
      chk("model tx_data", int'(tx_data), int'(m_data));
      chk("model overflow", int'(overflow), int'(m_ovf));
   endtask

   initial begin
      int quiet;
      int k;
      int nxt;
      int nobs;

      // Directed table: inputs applied for one cycle, outputs expected after that edge.
      //   v  data   rdy clr rst | lvl stb data   ovf
      row(0, 8'h00, 0,  0,  1,    0,  0,  8'h00, 0);
      row(1, 8'h41, 1,  0,  0,    1,  0,  8'h00, 0);   // write into empty: no pop yet
      row(1, 8'h42, 1,  0,  0,    1,  1,  8'h41, 0);   // pop 0x41, write 0x42
      row(0, 8'h00, 1,  0,  0,    1,  0,  8'h41, 0);   // stale-high ready ignored
      row(0, 8'h00, 1,  0,  0,    1,  0,  8'h41, 0);
      row(0, 8'h00, 1,  0,  0,    1,  0,  8'h41, 0);
      row(0, 8'h00, 1,  0,  0,    1,  0,  8'h41, 0);
      row(0, 8'h00, 1,  0,  0,    0,  1,  8'h42, 0);   // second strobe 5 cycles later
      row(0, 8'h00, 0,  0,  0,    0,  0,  8'h42, 0);
      row(1, 8'h55, 0,  0,  0,    1,  0,  8'h42, 0);
      row(0, 8'h00, 0,  0,  0,    1,  0,  8'h42, 0);
      row(0, 8'h00, 1,  0,  0,    1,  0,  8'h42, 0);
      row(0, 8'h00, 1,  0,  1,    0,  0,  8'h00, 0);   // reset on the pop cycle
      row(1, 8'h66, 1,  0,  0,    1,  0,  8'h00, 0);
      row(0, 8'h00, 1,  0,  0,    0,  1,  8'h66, 0);   // back in idle: normal latency
      row(0, 8'h00, 0,  0,  0,    0,  0,  8'h66, 0);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].rst);
         chk($sformatf("row%0d level", i), int'(level), tbl[i].lvl);
         chk($sformatf("row%0d empty", i), int'(empty), int'(tbl[i].lvl == 0));
         chk($sformatf("row%0d in_ready", i), int'(in_ready), int'(tbl[i].lvl != Depth));
         chk($sformatf("row%0d tx_strobe", i), int'(tx_strobe), int'(tbl[i].stb));
         chk($sformatf("row%0d tx_data", i), int'(tx_data), int'(tbl[i].dat));
         chk($sformatf("row%0d overflow", i), int'(overflow), int'(tbl[i].ovf));
      end

      // Slow transmitter: ready low for 40 cycles after each strobe.
      cycle(0, 8'h00, 0, 0, 1);
      obs_cyc.delete();
      obs_data.delete();
      quiet = 0;
      k = 0;
      for (int n = 0; n < 260; n++) begin
         bit v;
         v = (k < 4);
         cycle(v, 8'(8'h10 + k), quiet == 0, 0, 0);
         if (v && m_wr) k++;
         if (m_strobe) quiet = 40;
         else if (quiet > 0) quiet--;
      end
      chk("slow strobe count", obs_data.size(), 4);
      nobs = (obs_data.size() < 4) ? obs_data.size() : 4;
      for (int i = 0; i < nobs; i++) begin
         chk($sformatf("slow byte%0d", i), int'(obs_data[i]), 8'h10 + i);
         if (i > 0) chk($sformatf("slow gap%0d>=40", i), int'(obs_cyc[i] - obs_cyc[i-1] >= 40), 1);
      end

      // Fill to full, overflow, clear, then pop-while-full and wrap over 40 bytes.
      cycle(0, 8'h00, 0, 0, 1);
      obs_cyc.delete();
      obs_data.delete();
      for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0);
      chk("full level", int'(level), 16);
      chk("full in_ready", int'(in_ready), 0);
      cycle(1, 8'hEE, 0, 0, 0);
      chk("overflow set", int'(overflow), 1);
      chk("overflow level", int'(level), 16);
      cycle(0, 8'h00, 0, 1, 0);
      chk("overflow cleared", int'(overflow), 0);
      nxt = 16;
      cycle(1, 8'(nxt), 1, 0, 0);
      chk("no write on pop", int'(level), 15);
      if (m_wr) nxt++;
      cycle(1, 8'(nxt), 1, 0, 0);
      chk("write after pop", int'(level), 16);
      if (m_wr) nxt++;
      for (int n = 0; n < 500 && obs_data.size() < 40; n++) begin
         bit v;
         v = (nxt < 40);
         cycle(v, 8'(nxt), 1, 0, 0);
         if (v && m_wr) nxt++;
      end
      chk("wrap bytes delivered", obs_data.size(), 40);
      nobs = (obs_data.size() < 40) ? obs_data.size() : 40;
      for (int i = 0; i < nobs; i++) chk($sformatf("wrap byte%0d", i), int'(obs_data[i]), i);

      // Ready held high: strobes exactly Holdoff+3 apart.
      cycle(0, 8'h00, 0, 0, 1);
      obs_cyc.delete();
      obs_data.delete();
      for (int i = 0; i < 3; i++) cycle(1, 8'(8'hA0 + i), 0, 0, 0);
      for (int n = 0; n < 30; n++) cycle(0, 8'h00, 1, 0, 0);
      chk("fast strobe count", obs_data.size(), 3);
      nobs = (obs_data.size() < 3) ? obs_data.size() : 3;
      for (int i = 0; i < nobs; i++) begin
         chk($sformatf("fast byte%0d", i), int'(obs_data[i]), 8'hA0 + i);
         if (i > 0) chk($sformatf("fast gap%0d", i), obs_cyc[i] - obs_cyc[i-1], Holdoff + 3);
      end

      // Random traffic in phases alternating producer-heavy and drain-heavy.
      cycle(0, 8'h00, 0, 0, 1);
      for (int n = 0; n < 2000; n++) begin
         bit v, rdy, clr, rst;
         int vp, rp;
         vp = ((n / 400) % 2 == 0) ? 70 : 30;
         rp = ((n / 400) % 2 == 0) ? 15 : 80;
         v = ($urandom_range(0, 99) < vp);
         rdy = ($urandom_range(0, 99) < rp);
         clr = ($urandom_range(0, 99) < 5);
         rst = ($urandom_range(0, 399) == 0);
         cycle(v, 8'($urandom), rdy, clr, rst);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
